// File: rtl/ofdm_pkg.sv
// Shared types and helpers for the OFDM cyclic-prefix insertion block.
package ofdm_pkg;

  // Default output sample width after scaling the IFFT result.
  localparam int DATA_SIZE_DEF = 16;

  // Symbol handling phases: fill the buffer, emit the prefix, emit the body.
  typedef enum logic [1:0] {
    LOAD,
    OUT_CP,
    OUT_BODY
  } state_t;

  // Address width needed to index a buffer of the given depth (at least 1 bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ofdm_cp_ram.sv
// Symbol buffer: simple dual-port RAM with a registered, enabled read port.
// A read that hits the address being written returns the new data, so the
// prefix read can start on the same cycle the last sample is written.
module ofdm_cp_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port plus registered read port with write-first bypass.
  // NOTE: the storage array has no reset; clearing it would prevent RAM
  // inference and every word is written before it is ever read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix insertion: buffers one IFFT symbol, scales it by truncation,
// then streams the last CP_LEN samples followed by the whole symbol.
// Read side is a two-stage pipeline (RAM output, then output register) so
// that the output can hold under back-pressure without losing samples.
module ofdm_cp_insert
  import ofdm_pkg::*;
#(
  parameter int IN_SIZE   = 22,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int FFT_SIZE  = 64,
  parameter int CP_LEN    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [IN_SIZE-1:0]   i_data_i,
  input  logic [IN_SIZE-1:0]   i_data_q,
  output logic                 o_wayt_data,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_data_i,
  output logic [DATA_SIZE-1:0] o_data_q,
  output logic                 o_sop,
  output logic                 o_eop,
  input  logic                 i_wayt_recive,
  output logic [15:0]          o_symbol_cnt
);

  localparam int AW = addr_width(FFT_SIZE);
  typedef logic [AW-1:0] addr_t;
  localparam addr_t LAST     = addr_t'(FFT_SIZE - 1);
  localparam addr_t CP_START = addr_t'(FFT_SIZE - CP_LEN);

  state_t state, state_nx;
  addr_t  wr_cnt, wr_cnt_nx, rd_addr, rd_addr_nx, issue_addr;
  logic   body_done, body_done_nx;
  logic   issue, issue_sop, issue_eop, we;

  logic                   m_valid, m_sop, m_eop;
  logic [2*DATA_SIZE-1:0] ram_q, wdata;
  logic                   out_free, mid_free, out_xfer;

  // Low input bits are discarded by the truncating scaler.
  logic unused_low_bits;
  assign unused_low_bits = ^{i_data_i[IN_SIZE-DATA_SIZE-1:0], i_data_q[IN_SIZE-DATA_SIZE-1:0]};

  assign out_free = !o_valid || i_wayt_recive;
  assign mid_free = !m_valid || out_free;
  assign out_xfer = o_valid && i_wayt_recive;
  assign wdata    = {i_data_i[IN_SIZE-1 -: DATA_SIZE], i_data_q[IN_SIZE-1 -: DATA_SIZE]};

  // FSM and address counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= LOAD;
      wr_cnt    <= '0;
      rd_addr   <= '0;
      body_done <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_cnt    <= wr_cnt_nx;
      rd_addr   <= rd_addr_nx;
      body_done <= body_done_nx;
    end
  end

  // Next-state, buffer write and read-issue decisions.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx     = state;
    wr_cnt_nx    = wr_cnt;
    rd_addr_nx   = rd_addr;
    body_done_nx = body_done;
    o_wayt_data  = 1'b0;
    we           = 1'b0;
    issue        = 1'b0;
    issue_addr   = rd_addr;
    issue_sop    = 1'b0;
    issue_eop    = 1'b0;
    case (state)
      LOAD: begin
        o_wayt_data = 1'b1;
        if (i_valid) begin
          we        = 1'b1;
          wr_cnt_nx = wr_cnt + 1'b1;
          if (wr_cnt == LAST) begin
            // The pipeline is empty here, so the first read issues at once.
            wr_cnt_nx = '0;
            issue     = 1'b1;
            issue_sop = 1'b1;
            if (CP_LEN == 0) begin
              issue_addr = '0;
              rd_addr_nx = addr_t'(1);
              state_nx   = OUT_BODY;
            end else begin
              issue_addr = CP_START;
              rd_addr_nx = addr_t'(CP_START + 1'b1);
              state_nx   = (CP_LEN == 1) ? OUT_BODY : OUT_CP;
            end
          end
        end
      end
      OUT_CP: begin
        if (mid_free) begin
          issue      = 1'b1;
          rd_addr_nx = rd_addr + 1'b1;
          if (rd_addr == LAST) state_nx = OUT_BODY;
        end
      end
      OUT_BODY: begin
        if (mid_free && !body_done) begin
          issue      = 1'b1;
          issue_eop  = (rd_addr == LAST);
          rd_addr_nx = rd_addr + 1'b1;
          if (rd_addr == LAST) body_done_nx = 1'b1;
        end
        if (out_xfer && o_eop) begin
          state_nx     = LOAD;
          body_done_nx = 1'b0;
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  ofdm_cp_ram #(
    .DEPTH(FFT_SIZE),
    .WIDTH(2 * DATA_SIZE),
    .AW   (AW)
  ) u_ram (
    .clk  (i_clk),
    .we   (we),
    .waddr(wr_cnt),
    .wdata(wdata),
    .re   (issue),
    .raddr(issue_addr),
    .q    (ram_q)
  );

  // Read pipeline: RAM-output tags, output hold register and symbol counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      m_valid      <= 1'b0;
      m_sop        <= 1'b0;
      m_eop        <= 1'b0;
      o_valid      <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_data_i     <= '0;
      o_data_q     <= '0;
      o_symbol_cnt <= '0;
    end else begin
      if (mid_free) begin
        m_valid <= issue;
        m_sop   <= issue_sop;
        m_eop   <= issue_eop;
      end
      if (out_free) begin
        o_valid <= m_valid;
        o_sop   <= m_valid && m_sop;
        o_eop   <= m_valid && m_eop;
        if (m_valid) begin
          o_data_i <= ram_q[2*DATA_SIZE-1:DATA_SIZE];
          o_data_q <= ram_q[DATA_SIZE-1:0];
        end
      end
      if (out_xfer && o_eop) o_symbol_cnt <= o_symbol_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Self-checking bench for ofdm_cp_insert: default 64/16 instance with a
// scoreboard, plus an 8-point, no-prefix instance for truncation and edges.
module tb_ofdm_cp_insert;

  localparam int FFT  = 64;
  localparam int CP   = 16;
  localparam int NOUT = FFT + CP;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic        sop;
    logic        eop;
  } exp_t;

  typedef struct {
    logic [21:0] in_i;
    logic [21:0] in_q;
    logic [15:0] exp_i;
    logic [15:0] exp_q;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Default instance.
  logic        rst = 1'b1, vld = 1'b0, rdy = 1'b1;
  logic [21:0] di = '0, dq = '0;
  logic        wayt, ovld, osop, oeop;
  logic [15:0] oi, oq, scnt;

  // Small instance: FFT_SIZE=8, CP_LEN=0.
  logic        rst8 = 1'b1, vld8 = 1'b0, rdy8 = 1'b1;
  logic [21:0] di8 = '0, dq8 = '0;
  logic        wayt8, ovld8, osop8, oeop8;
  logic [15:0] oi8, oq8, scnt8;

  exp_t sb[$];
  exp_t sb8[$];
  int   out_cnt  = 0;
  int   out_cnt8 = 0;
  bit   rand_rdy = 1'b0;

  ofdm_cp_insert dut (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_data_i(di), .i_data_q(dq),
    .o_wayt_data(wayt), .o_valid(ovld), .o_data_i(oi), .o_data_q(oq),
    .o_sop(osop), .o_eop(oeop), .i_wayt_recive(rdy), .o_symbol_cnt(scnt)
  );

  ofdm_cp_insert #(.FFT_SIZE(8), .CP_LEN(0)) dut8 (
    .i_clk(clk), .i_reset(rst8), .i_valid(vld8), .i_data_i(di8), .i_data_q(dq8),
    .o_wayt_data(wayt8), .o_valid(ovld8), .o_data_i(oi8), .o_data_q(oq8),
    .o_sop(osop8), .o_eop(oeop8), .i_wayt_recive(rdy8), .o_symbol_cnt(scnt8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_sample(input string tag, input exp_t e, input logic [15:0] gi,
                            input logic [15:0] gq, input logic gs, input logic ge);
    check({tag, "_i"},   32'(gi), 32'(e.i));
    check({tag, "_q"},   32'(gq), 32'(e.q));
    check({tag, "_sop"}, 32'(gs), 32'(e.sop));
    check({tag, "_eop"}, 32'(ge), 32'(e.eop));
  endtask

  // Downstream ready: held high or toggled pseudo-randomly.
  always @(posedge clk) begin
    #1;
    rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Main-instance monitor: scoreboard pop on transfer, hold check on stall.
  logic        hold_prev = 1'b0;
  logic [15:0] p_i, p_q;
  logic        p_s, p_e;
  exp_t        e_m;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(ovld), 32'd1);
        check("hold_i",     32'(oi),   32'(p_i));
        check("hold_q",     32'(oq),   32'(p_q));
        check("hold_sop",   32'(osop), 32'(p_s));
        check("hold_eop",   32'(oeop), 32'(p_e));
      end
      if (ovld) check("wayt_low_in_emit", 32'(wayt), 32'd0);
      if (ovld && rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e_m = sb.pop_front();
          cmp_sample("out", e_m, oi, oq, osop, oeop);
        end
        out_cnt++;
      end
      hold_prev = ovld && !rdy;
      p_i = oi; p_q = oq; p_s = osop; p_e = oeop;
    end
  end

  // Small-instance monitor.
  exp_t e_8;
  always @(negedge clk) begin
    if (!rst8) begin
      if (ovld8) check("wayt8_low_in_emit", 32'(wayt8), 32'd0);
      if (ovld8 && rdy8) begin
        if (sb8.size() == 0) begin
          check("unexpected_output8", 32'd1, 32'd0);
        end else begin
          e_8 = sb8.pop_front();
          cmp_sample("out8", e_8, oi8, oq8, osop8, oeop8);
        end
        out_cnt8++;
      end
    end
  end

  task automatic send_sample(input logic [21:0] si, input logic [21:0] sq);
    int guard = 0;
    vld = 1'b1; di = si; dq = sq;
    while (!wayt) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL accept_timeout: o_wayt_data low for %0d cycles", guard);
        $fatal(1, "input never accepted");
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_sample8(input logic [21:0] si, input logic [21:0] sq);
    int guard = 0;
    vld8 = 1'b1; di8 = si; dq8 = sq;
    while (!wayt8) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL accept_timeout8: o_wayt_data low for %0d cycles", guard);
        $fatal(1, "input never accepted");
      end
    end
    @(posedge clk); #1;
  endtask

  // Sample k of a symbol carries value v=a*k+b scaled by 64; q is -v.
  task automatic send_main(input int a, input int b);
    for (int n = 0; n < NOUT; n++) begin
      int   j;
      int   v;
      exp_t e;
      j = (n < CP) ? (FFT - CP + n) : (n - CP);
      v = a * j + b;
      e.i = 16'(v); e.q = 16'(-v); e.sop = (n == 0); e.eop = (n == NOUT - 1);
      sb.push_back(e);
    end
    for (int k = 0; k < FFT; k++) begin
      int v;
      v = a * k + b;
      send_sample(22'(v <<< 6), 22'((-v) <<< 6));
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sb.size() != 0 || !wayt || ovld) && g < 3000) begin
      @(negedge clk); g++;
    end
    check("drain_timeout", 32'(g >= 3000), 32'd0);
  endtask

  task automatic wait_drain8();
    int g = 0;
    while ((sb8.size() != 0 || !wayt8 || ovld8) && g < 3000) begin
      @(negedge clk); g++;
    end
    check("drain8_timeout", 32'(g >= 3000), 32'd0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t tbl [8];
    int   last_xfer;
    int   g;

    // Truncation vectors: output = input[21:6].
    tbl[0] = '{22'h3FFFC0, 22'h1FFFFF, 16'hFFFF, 16'h7FFF};
    tbl[1] = '{22'h200000, 22'h000000, 16'h8000, 16'h0000};
    tbl[2] = '{22'h00003F, 22'h3FFFFF, 16'h0000, 16'hFFFF};
    tbl[3] = '{22'h000040, 22'h3FFFBF, 16'h0001, 16'hFFFE};
    tbl[4] = '{22'h1FFFC0, 22'h200040, 16'h7FFF, 16'h8001};
    tbl[5] = '{22'h123456, 22'h3ABCDE, 16'h48D1, 16'hEAF3};
    tbl[6] = '{22'h0000C0, 22'h000100, 16'h0003, 16'h0004};
    tbl[7] = '{22'h3FFF80, 22'h00FFC0, 16'hFFFE, 16'h03FF};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst8 = 1'b0;

    // Reset state.
    check("rst_valid", 32'(ovld), 32'd0);
    check("rst_wayt",  32'(wayt), 32'd1);
    check("rst_cnt",   32'(scnt), 32'd0);
    check("rst_i",     32'(oi),   32'd0);
    check("rst_q",     32'(oq),   32'd0);
    check("rst_sop",   32'(osop), 32'd0);
    check("rst_eop",   32'(oeop), 32'd0);
    check("rst8_wayt", 32'(wayt8), 32'd1);

    // 1: ramp symbol at full rate, latency and count.
    out_cnt = 0;
    send_main(1, 0);
    last_xfer = cyc - 1;
    vld = 1'b0;
    g = 0;
    while (!ovld && g < 20) begin
      @(negedge clk); g++;
    end
    check("latency", 32'(cyc - last_xfer), 32'd2);
    wait_drain();
    check("t1_symbol_cnt", 32'(scnt), 32'd1);
    check("t1_out_count",  32'(out_cnt), 32'(NOUT));

    // 2: same symbol under random back-pressure.
    rand_rdy = 1'b1;
    out_cnt  = 0;
    send_main(1, 0);
    vld = 1'b0;
    wait_drain();
    rand_rdy = 1'b0;
    check("t2_symbol_cnt", 32'(scnt), 32'd2);
    check("t2_out_count",  32'(out_cnt), 32'(NOUT));

    // 3: three symbols back to back with i_valid held high.
    reset_pulse();
    out_cnt = 0;
    send_main(3, 5);
    send_main(-7, 100);
    send_main(11, -2000);
    vld = 1'b0;
    wait_drain();
    check("t3_symbol_cnt", 32'(scnt), 32'd3);
    check("t3_out_count",  32'(out_cnt), 32'(3 * NOUT));

    // 4: reset in the middle of emission, then a fresh symbol.
    reset_pulse();
    out_cnt = 0;
    send_main(2, 1);
    vld = 1'b0;
    g = 0;
    while (out_cnt < 30 && g < 500) begin
      @(negedge clk); #1; g++;
    end
    check("t4_reach_idx30", 32'(out_cnt), 32'd30);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("t4_valid", 32'(ovld), 32'd0);
    check("t4_i",     32'(oi),   32'd0);
    check("t4_q",     32'(oq),   32'd0);
    check("t4_wayt",  32'(wayt), 32'd1);
    check("t4_cnt",   32'(scnt), 32'd0);
    out_cnt = 0;
    repeat (100) @(posedge clk);
    #1;
    check("t4_no_stale_output", 32'(out_cnt), 32'd0);
    send_main(5, -9);
    vld = 1'b0;
    wait_drain();
    check("t4_symbol_cnt", 32'(scnt), 32'd1);
    check("t4_out_count",  32'(out_cnt), 32'(NOUT));

    // Truncation table through the 8-point, no-prefix instance.
    out_cnt8 = 0;
    for (int r = 0; r < 8; r++) begin
      exp_t e;
      e.i = tbl[r].exp_i; e.q = tbl[r].exp_q; e.sop = (r == 0); e.eop = (r == 7);
      sb8.push_back(e);
    end
    for (int r = 0; r < 8; r++) send_sample8(tbl[r].in_i, tbl[r].in_q);
    vld8 = 1'b0;
    wait_drain8();
    check("trunc_symbol_cnt", 32'(scnt8), 32'd1);
    check("trunc_out_count",  32'(out_cnt8), 32'd8);

    // 5: FFT_SIZE=8, CP_LEN=0, samples 1..8.
    out_cnt8 = 0;
    for (int k = 1; k <= 8; k++) begin
      exp_t e;
      e.i = 16'(k); e.q = 16'(-k); e.sop = (k == 1); e.eop = (k == 8);
      sb8.push_back(e);
    end
    for (int k = 1; k <= 8; k++) send_sample8(22'(k <<< 6), 22'((-k) <<< 6));
    vld8 = 1'b0;
    wait_drain8();
    check("t5_symbol_cnt", 32'(scnt8), 32'd2);
    check("t5_out_count",  32'(out_cnt8), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
